// File: rtl/lsu_mem_responder.sv
// Data-memory responder for the LSU memory port: word-addressed SRAM model with byte-masked
// stores, offset-aligned loads and one response pulse per request. Optional random extra latency: LSU_MEM_RAND_DELAY_EN.
module lsu_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_wen_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wmask_i,
    output logic        mem_rvalid_o,
    output logic [31:0] mem_rdata_o,
    output logic        busy_o,
    output logic        err_oob_o,
    output logic        err_overlap_o
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic        accept_s;
    logic        overlap_s;
    logic [3:0]  start_cnt_s;
    logic [31:0] rd_addr_s;
    logic        rd_wen_s;
    logic [31:0] rd_word_s;
    logic [31:0] rdata_s;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        busy_q;
    logic        err_oob_q;
    logic        err_overlap_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    function automatic logic [31:0] offset_f(input logic [31:0] addr);
        return addr - BASE_ADDR;
    endfunction

    // Unsigned wrap makes addresses below the base land far out of range.
    function automatic logic oob_f(input logic [31:0] addr);
        return (offset_f(addr) >> (AW + 2)) != 32'd0;
    endfunction

    function automatic logic [AW-1:0] index_f(input logic [31:0] addr);
        return AW'(offset_f(addr) >> 2);
    endfunction

    function automatic logic [31:0] align_f(input logic [31:0] word, input logic [1:0] ofs);
        return word >> {ofs, 3'b000};
    endfunction

`ifdef LSU_MEM_RAND_DELAY_EN
    logic [3:0] lfsr_q, lfsr_d;
    logic [4:0] lat_sum_s;

    // LFSR advances once per accepted request.
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept_s) begin
            lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 4'b1001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Total latency capped at 15, i.e. a start count of at most 14.
    assign lat_sum_s   = {1'b0, LAT_M1} + {3'b000, lfsr_q[1:0]};
    assign start_cnt_s = (lat_sum_s > 5'd14) ? 4'd14 : lat_sum_s[3:0];
`else
    assign start_cnt_s = LAT_M1;
`endif

    // Next-state logic: acceptance in IDLE, RESP, or (as an overlap) in WAIT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        accept_s  = 1'b0;
        overlap_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    accept_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_req_i) begin
                    accept_s  = 1'b1;
                    overlap_s = 1'b1;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (mem_req_i) begin
                    accept_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (accept_s) begin
            addr_d  = mem_addr_i;
            wen_d   = mem_wen_i;
            cnt_d   = start_cnt_s;
            state_d = (start_cnt_s == 4'd0) ? ST_RESP : ST_WAIT;
        end else begin
            addr_d = addr_q;
            wen_d  = wen_q;
        end
    end

    // A single-cycle latency reads for the request being accepted right now.
    assign rd_addr_s = accept_s ? mem_addr_i : addr_q;
    assign rd_wen_s  = accept_s ? mem_wen_i : wen_q;
    assign rd_word_s = mem_q[index_f(rd_addr_s)];

    // Load data: zero for stores and out-of-range, else right-aligned to the byte offset.
    always_comb begin
        rdata_s = 32'd0;
        if (rd_wen_s || oob_f(rd_addr_s)) begin
            rdata_s = 32'd0;
        end else begin
            rdata_s = align_f(rd_word_s, rd_addr_s[1:0]);
        end
    end

    // Byte-masked store committed at the acceptance edge; array is never reset.
    always_ff @(posedge clk) begin
        if (!rst && accept_s && mem_wen_i && !oob_f(mem_addr_i)) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask_i[i]) begin
                    mem_q[index_f(mem_addr_i)][8*i +: 8] <= mem_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // State, transaction and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            addr_q        <= 32'd0;
            wen_q         <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= 32'd0;
            busy_q        <= 1'b0;
            err_oob_q     <= 1'b0;
            err_overlap_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wen_q         <= wen_d;
            rvalid_q      <= (state_d == ST_RESP);
            busy_q        <= (state_d != ST_IDLE);
            err_oob_q     <= err_oob_q | (accept_s & oob_f(mem_addr_i));
            err_overlap_q <= err_overlap_q | overlap_s;
            if (state_d == ST_RESP) begin
                rdata_q <= rdata_s;
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    assign mem_rvalid_o  = rvalid_q;
    assign mem_rdata_o   = rdata_q;
    assign busy_o        = busy_q;
    assign err_oob_o     = err_oob_q;
    assign err_overlap_o = err_overlap_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Self-checking bench for lsu_mem_responder: directed steps plus randomized loads/stores
// checked against a byte-level memory model and a latency model.
module tb_lsu_mem_responder;

    localparam int          LAT   = 2;
    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] RB    = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err_oob;
    logic        err_overlap;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] mem_m [int unsigned];
`ifdef LSU_MEM_RAND_DELAY_EN
    int unsigned lfsr_m;
`endif

    always #5 clk = ~clk;

    lsu_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_i    (mem_req),
        .mem_wen_i    (mem_wen),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .mem_wmask_i  (mem_wmask),
        .mem_rvalid_o (mem_rvalid),
        .mem_rdata_o  (mem_rdata),
        .busy_o       (busy),
        .err_oob_o    (err_oob),
        .err_overlap_o(err_overlap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] mask);
        int unsigned b;
        if (in_range(addr)) begin
            b = (addr - BASE) & 32'hFFFF_FFFC;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) mem_m[b + 32'(i)] = wdata[8*i +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr);
        logic [31:0] r;
        int unsigned b;
        int unsigned sh;
        r = 32'd0;
        if (in_range(addr)) begin
            b  = (addr - BASE) & 32'hFFFF_FFFC;
            sh = (addr - BASE) & 32'd3;
            for (int unsigned k = sh; k < 4; k++) begin
                r = r | (32'(mem_m[b + k]) << (8 * (k - sh)));
            end
        end
        return r;
    endfunction

    function automatic int next_lat();
`ifdef LSU_MEM_RAND_DELAY_EN
        int l;
        int unsigned fb;
        l = LAT + int'(lfsr_m % 4);
        if (l > 15) l = 15;
        fb = ((lfsr_m >> 3) ^ (lfsr_m >> 2)) & 32'd1;
        lfsr_m = ((lfsr_m * 2) + fb) % 16;
        return l;
`else
        return LAT;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask);
        mem_req   = 1'b1;
        mem_wen   = wen;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wmask = mask;
    endtask

    task automatic transact(input string tag, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask);
        int l;
        logic [31:0] exp_d;
        l = next_lat();
        if (wen) begin
            model_store(addr, wdata, mask);
            exp_d = 32'd0;
        end else begin
            exp_d = model_load(addr);
        end
        drive(wen, addr, wdata, mask);
        for (int k = 1; k <= l + 2; k++) begin
            tick();
            if (k == 1) mem_req = 1'b0;
            check({tag, ".rvalid"}, 32'(mem_rvalid), 32'(k == l));
            check({tag, ".busy"}, 32'(busy), 32'(k <= l));
            if (k == l || k == l + 2) check({tag, ".rdata"}, mem_rdata, exp_d);
        end
    endtask

    initial begin
        int la;
        int lb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] wd;

        rst       = 1'b1;
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wmask = 4'd0;
`ifdef LSU_MEM_RAND_DELAY_EN
        lfsr_m = 9;
`endif
        repeat (3) tick();
        check("rst.rvalid", 32'(mem_rvalid), 32'd0);
        check("rst.rdata", mem_rdata, 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.err_oob", 32'(err_oob), 32'd0);
        check("rst.err_overlap", 32'(err_overlap), 32'd0);
        rst = 1'b0;
        tick();

        // Directed word, byte, half-word and empty-mask traffic.
        transact("sw", 1'b1, 32'h8000_0010, 32'h1234_5678, 4'b1111);
        transact("lw", 1'b0, 32'h8000_0010, 32'd0, 4'd0);
        transact("sb", 1'b1, 32'h8000_0013, 32'hAB00_0000, 4'b1000);
        transact("lb", 1'b0, 32'h8000_0013, 32'd0, 4'd0);
        transact("lh", 1'b0, 32'h8000_0012, 32'd0, 4'd0);
        transact("s0", 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000);
        transact("lw0", 1'b0, 32'h8000_0010, 32'd0, 4'd0);
        check("lw0.const", mem_rdata, 32'hAB34_5678);

        // Randomized traffic over a 16-word region.
        for (int w = 0; w < 16; w++) begin
            transact("init", 1'b1, RB + 32'(4 * w), $urandom, 4'hF);
        end
        for (int n = 0; n < 40; n++) begin
            transact("rnd", 1'($urandom_range(0, 1)),
                     RB + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)),
                     $urandom, 4'($urandom_range(0, 15)));
        end
        check("rnd.err_oob", 32'(err_oob), 32'd0);
        check("rnd.err_overlap", 32'(err_overlap), 32'd0);

        // Back-to-back: second request sampled in the response cycle of the first.
        la = next_lat();
        ea = model_load(RB + 32'd4);
        drive(1'b0, RB + 32'd4, 32'd0, 4'd0);
        for (int k = 1; k <= la; k++) begin
            tick();
            if (k == 1) mem_req = 1'b0;
            check("b2b.a.rvalid", 32'(mem_rvalid), 32'(k == la));
            if (k == la) check("b2b.a.rdata", mem_rdata, ea);
        end
        lb = next_lat();
        eb = model_load(RB + 32'd9);
        drive(1'b0, RB + 32'd9, 32'd0, 4'd0);
        for (int j = 1; j <= lb + 1; j++) begin
            tick();
            if (j == 1) mem_req = 1'b0;
            check("b2b.b.rvalid", 32'(mem_rvalid), 32'(j == lb));
            check("b2b.b.busy", 32'(busy), 32'(j <= lb));
            if (j == lb) check("b2b.b.rdata", mem_rdata, eb);
        end

        // Out-of-range accesses below the base and past the top.
        transact("w0", 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF);
        transact("oob.lw", 1'b0, 32'h7FFF_FFFC, 32'd0, 4'd0);
        check("oob.lw.rdata", mem_rdata, 32'd0);
        check("oob.err", 32'(err_oob), 32'd1);
        transact("oob.sw", 1'b1, 32'h8000_4000, 32'hDEAD_BEEF, 4'hF);
        transact("oob.chk", 1'b0, 32'h8000_0000, 32'd0, 4'd0);
        check("oob.chk.const", mem_rdata, 32'hCAFE_F00D);
        check("oob.sticky", 32'(err_oob), 32'd1);

        // Overlap: a new store arrives while the load is still waiting.
        check("ovl.pre", 32'(err_overlap), 32'd0);
        void'(next_lat());
        drive(1'b0, RB, 32'd0, 4'd0);
        tick();
        check("ovl.first.rvalid", 32'(mem_rvalid), 32'd0);
        wd = $urandom;
        lb = next_lat();
        model_store(RB + 32'd12, wd, 4'hF);
        drive(1'b1, RB + 32'd12, wd, 4'hF);
        for (int j = 1; j <= lb + 2; j++) begin
            tick();
            if (j == 1) mem_req = 1'b0;
            check("ovl.rvalid", 32'(mem_rvalid), 32'(j == lb));
            check("ovl.busy", 32'(busy), 32'(j <= lb));
            if (j == lb) check("ovl.rdata", mem_rdata, 32'd0);
        end
        check("ovl.err", 32'(err_overlap), 32'd1);
        transact("ovl.lw", 1'b0, RB + 32'd12, 32'd0, 4'd0);

        // Reset in the middle of a store's wait: no response, store kept.
        wd = $urandom;
        void'(next_lat());
        model_store(RB + 32'd20, wd, 4'hF);
        drive(1'b1, RB + 32'd20, wd, 4'hF);
        tick();
        mem_req = 1'b0;
        check("mid.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        check("mid.rvalid", 32'(mem_rvalid), 32'd0);
        check("mid.rdata", mem_rdata, 32'd0);
        check("mid.busy0", 32'(busy), 32'd0);
        check("mid.err_oob", 32'(err_oob), 32'd0);
        check("mid.err_overlap", 32'(err_overlap), 32'd0);
        rst = 1'b0;
`ifdef LSU_MEM_RAND_DELAY_EN
        lfsr_m = 9;
`endif
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post.rvalid", 32'(mem_rvalid), 32'd0);
            check("post.busy", 32'(busy), 32'd0);
        end
        transact("post.lw", 1'b0, RB + 32'd20, 32'd0, 4'd0);
        check("post.lw.const", mem_rdata, wd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsu_mem_responder.md
# lsu_mem_responder

Data-memory responder for the pipeline LSU's memory port. It accepts the LSU's single-cycle `mem_req` pulse, holds a word-addressed SRAM model, and performs byte-masked stores and offset-aligned loads. For every request, loads and stores alike, it returns exactly one `mem_rvalid` pulse after a bounded latency. It sits between the LSU and the data-memory/bus fabric and is also the bench's data memory.

## Interface
Parameters:
- `DEPTH_WORDS`, 4096: number of 32-bit words in the array (power of 2).
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `LATENCY`, 2: cycles from request cycle to `mem_rvalid`; legal range 1..15.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_req`  in  1  request pulse, one cycle per transaction.
- `mem_wen`  in  1  1 = store, 0 = load; sampled with `mem_req`.
- `mem_addr`  in  32  byte address; sampled with `mem_req`.
- `mem_wdata`  in  32  store data, already lane-shifted by the initiator.
- `mem_wmask`  in  4  byte-lane enables, bit i = byte lane i.
- `mem_rvalid`  out  1  response pulse, exactly one cycle per accepted request.
- `mem_rdata`  out  32  load data right-aligned to the byte offset; 0 for stores.
- `busy`  out  1  1 while a transaction is outstanding.
- `err_oob`  out  1  sticky flag: an out-of-range address was accepted.
- `err_overlap`  out  1  sticky flag: `mem_req` arrived while `busy`.

## Operation
- States are IDLE, WAIT and RESP.
- IDLE, when `mem_req` = 1:
  - latch `mem_addr`, `mem_wen`, `mem_wdata` and `mem_wmask`;
  - load a countdown with `LATENCY-1` (plus random extra, see Configuration);
  - go to RESP if the count is 0, otherwise WAIT.
- WAIT: decrement the count each cycle; at 1, go to RESP.
- RESP: lasts one cycle and asserts `mem_rvalid`; next state is IDLE. If `mem_req` = 1 in the same cycle, the new request is accepted as in IDLE.
- Stores commit at the acceptance edge. For each i with `mem_wmask[i]` = 1, byte i of the word is written.
- An all-zero mask still produces a response.
- Word index = `(addr - BASE_ADDR) >> 2`.
- Loads read the array at the RESP transition, so a store accepted earlier is always visible. Returned data = `word >> (8*addr[1:0])`, with upper bytes zero-filled. The initiator does its own sign/zero extension from bit 0.
- Out of range means `addr - BASE_ADDR >= 4*DEPTH_WORDS`, with unsigned wrap; addresses below the base are therefore out of range. For such a request:
  - the store is dropped;
  - the load returns 0;
  - the response is still given;
  - `err_oob` sets.
- `mem_req` while in WAIT (initiator flushed and re-issued):
  - the in-flight response is abandoned; a store from it is already committed;
  - the new request restarts the countdown;
  - `err_overlap` sets.
- `mem_rdata` holds its value between pulses. It is 0 after a store response.

## Timing
- Request sampled at cycle T; `mem_rvalid` is high only in cycle T+LATENCY (plus random extra when enabled).
- Throughput: back-to-back requests at T and T+LATENCY give responses at T+LATENCY and T+2·LATENCY.
- `busy` = 1 from T+1 through T+LATENCY inclusive.
- Reset values:
  - state IDLE, count 0;
  - `mem_rvalid` 0, `mem_rdata` 0, `busy` 0;
  - `err_oob` 0, `err_overlap` 0.
- Array contents are not reset.
- Reset mid-transaction aborts it: no response. A store already accepted is kept.

## Configuration
- `LSU_MEM_RAND_DELAY_EN` defined:
  - a 4-bit LFSR (taps x^4+x^3+1, reset seed 4'b1001) steps once per accepted request;
  - `lfsr[1:0]` is added to that request's latency, giving 0..3 extra cycles;
  - effective latency is capped at 15.
- `LSU_MEM_RAND_DELAY_EN` undefined: latency is exactly `LATENCY`, and no LFSR is instantiated.

## Test plan
- SW 0x8000_0010, wdata 0x1234_5678, mask 4'b1111, LATENCY = 2 -> `mem_rvalid` only at T+2. Then LW at the same address -> `mem_rdata` = 0x1234_5678.
- SB at 0x8000_0013 with wdata 0xAB00_0000, mask 4'b1000 -> word becomes 0xAB34_5678. LB at 0x8000_0013 -> `mem_rdata` = 0x0000_00AB.
- LH at 0x8000_0012 after the above -> `mem_rdata` = 0x0000_AB34. A store with mask 4'b0000 -> response given, word unchanged.
- LW at 0x7FFF_FFFC -> `mem_rdata` = 0, `err_oob` = 1 and stays 1. SW at 0x8000_4000 (DEPTH 4096) -> no array change.
- LW accepted at T, new SW accepted at T+1 (LATENCY = 3) -> exactly one `mem_rvalid`, at T+4; `err_overlap` = 1. `rst` pulsed mid-WAIT -> no response, all outputs 0.
- With `LSU_MEM_RAND_DELAY_EN`: 16 requests -> latencies match the LFSR-predicted 2..5 sequence; exactly one `mem_rvalid` per request.
